// File: rtl/ps2_frame_rec.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 lines, decodes 11-bit frames.
// Result pulses are registered, one clk after the stop-bit sample; a stalled partial frame aborts via timeout.
module ps2_frame_rec #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] dout,
  output logic       dout_new,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);

  typedef enum logic [1:0] {IDLE_ST, DATA_ST, PARITY_ST, STOP_ST} state_t;

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          filt_q, filt_dly_q;
  logic [FW-1:0] filt_cnt_q;
  logic          sample_evt;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    dout_q, dout_d;
  logic          new_q, new_d, perr_q, perr_d, ferr_q, ferr_d;

  // Lines idle high, so the synchronizers and filter reset to 1.
  always_ff @(posedge clk) begin
    if (resetN) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_dly_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_dly_q  <= filt_q;
      if (clk_sync_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_LAST) begin
        filt_q     <= clk_sync_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FILT_ONE;
      end
    end
  end

  assign sample_evt = filt_dly_q & ~filt_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    dout_d    = dout_q;
    new_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    to_cnt_d  = to_cnt_q;

    if (state_q == IDLE_ST || sample_evt) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LAST) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end

    case (state_q)
      IDLE_ST: begin
        if (sample_evt && !data_sync_q) begin
          bit_cnt_d = 3'd0;
          state_d   = DATA_ST;
        end
      end
      DATA_ST: begin
        if (sample_evt) begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY_ST;
        end
      end
      PARITY_ST: begin
        if (sample_evt) begin
          par_d   = data_sync_q;
          state_d = STOP_ST;
        end
      end
      STOP_ST: begin
        if (sample_evt) begin
          state_d = IDLE_ST;
          if (!data_sync_q) begin
            ferr_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            perr_d = 1'b1;
          end else begin
            dout_d = shift_q;
            new_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE_ST;
    endcase

    // A sample event in the same cycle overrides the timeout.
    if (state_q != IDLE_ST && !sample_evt && to_cnt_q == TO_LAST) begin
      state_d = IDLE_ST;
      ferr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q   <= IDLE_ST;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      dout_q    <= 8'h00;
      new_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      dout_q    <= dout_d;
      new_q     <= new_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_new   = new_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_frame_rec.sv
// Directed and randomized frame bench for ps2_frame_rec with a frame-level reference model.
module tb_ps2_frame_rec;
  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       resetN, ps2_clk, ps2_data;
  logic [7:0] dout;
  logic       dout_new, parity_err, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int viol = 0;
  int last_fall = 0;
  logic [7:0] model_dout;
  logic [9:0] evq[$];
  int         evt_cyc[$];

  ps2_frame_rec #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .resetN(resetN), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .dout(dout), .dout_new(dout_new), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: type 0 = good byte, 1 = parity error, 2 = frame error.
  always @(negedge clk) begin
    if (dout_new)   begin evq.push_back({2'd0, dout}); evt_cyc.push_back(cyc); end
    if (parity_err) begin evq.push_back({2'd1, dout}); evt_cyc.push_back(cyc); end
    if (frame_err)  begin evq.push_back({2'd2, dout}); evt_cyc.push_back(cyc); end
    if (32'(dout_new) + 32'(parity_err) + 32'(frame_err) > 1) viol++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(FL - 1);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 5 - (FL - 1));
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk   = 1'b0;
    last_fall = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int gl_bit);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], i == gl_bit);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  // Reference: odd parity over data+parity; stop error beats parity error.
  task automatic check_frame(input string tag, input logic [7:0] b, input logic par, input logic stp);
    logic [1:0] et;
    logic [9:0] ev;
    if (!stp) et = 2'd2;
    else if (((32'($countones(b)) + 32'(par)) % 2) == 0) et = 2'd1;
    else begin
      et = 2'd0;
      model_dout = b;
    end
    chk({tag, "_count"}, evq.size(), 1);
    if (evq.size() != 0) begin
      ev = evq.pop_front();
      chk({tag, "_kind"}, 32'(ev[9:8]), 32'(et));
      chk({tag, "_dout_at_pulse"}, 32'(ev[7:0]), 32'(model_dout));
    end
    chk({tag, "_dout_after"}, 32'(dout), 32'(model_dout));
    evq.delete();
    evt_cyc.delete();
  endtask

  initial begin
    logic [7:0] rb;
    logic       rpar, rstp;
    int         budget, lat;

    resetN = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_dout = 8'h00;
    wait_cyc(4);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_dout_new", 32'(dout_new), 0);
    chk("rst_parity_err", 32'(parity_err), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    resetN = 1'b0;
    wait_cyc(10);
    evq.delete(); evt_cyc.delete();

    send_frame(8'h1C, 1'b0, 1'b1, -1);  check_frame("good_1c", 8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1, -1);  check_frame("b2b_f0", 8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);  check_frame("b2b_1c", 8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1, -1);  check_frame("par_err", 8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b0, -1);  check_frame("stop_err", 8'h1C, 1'b1, 1'b0);

    // Partial frame: start + 3 data bits, then silence.
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    budget = 0;
    while (evq.size() == 0 && budget < TO + 200) begin
      wait_cyc(1);
      budget++;
    end
    chk("timeout_count", evq.size(), 1);
    if (evq.size() != 0) begin
      lat = evt_cyc[0] - last_fall;
      chk("timeout_kind", 32'(evq[0][9:8]), 2);
      chk("timeout_dout", 32'(evq[0][7:0]), 32'(model_dout));
      chk("timeout_latency_window", 32'((lat >= TO - 1) && (lat <= TO + FL + 8)), 1);
    end
    evq.delete(); evt_cyc.delete();
    wait_cyc(20);
    send_frame(8'h1C, 1'b0, 1'b1, -1);  check_frame("after_timeout", 8'h1C, 1'b0, 1'b1);

    // Idle glitch with data low would look like a start bit if it got through.
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
    wait_cyc(10);
    ps2_data = 1'b1;
    wait_cyc(30);
    chk("idle_glitch_quiet", evq.size(), 0);
    send_frame(8'hA5, 1'b1, 1'b1, 5);   check_frame("mid_glitch_a5", 8'hA5, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 4);   check_frame("mid_glitch_1c", 8'h1C, 1'b0, 1'b1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 1'b0);
    resetN = 1'b1;
    wait_cyc(3);
    ps2_data = 1'b1;
    chk("midrst_no_pulse", evq.size(), 0);
    chk("midrst_dout", 32'(dout), 32'h00);
    model_dout = 8'h00;
    resetN = 1'b0;
    wait_cyc(10);
    send_frame(8'h1C, 1'b0, 1'b1, -1);  check_frame("after_midrst", 8'h1C, 1'b0, 1'b1);

    for (int n = 0; n < 20; n++) begin
      rb   = 8'($urandom);
      rpar = (~^rb) ^ ($urandom_range(0, 3) == 0);
      rstp = ($urandom_range(0, 6) != 0);
      send_frame(rb, rpar, rstp, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 10)) : -1);
      check_frame("rand", rb, rpar, rstp);
    end

    wait_cyc(50);
    chk("no_stray_pulses", evq.size(), 0);
    chk("pulses_exclusive", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
